// File: rtl/skip_seq_counter_if.sv
// Control and status bundle for skip_seq_counter.
// The master drives the controls; the slave returns the count and wrap pulse.
interface skip_seq_counter_if #(
  parameter int WIDTH = 3
) ();
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (
    output en, up, load, din,
    input  q, tc
  );

  modport slave (
    input  en, up, load, din,
    output q, tc
  );
endinterface

// File: rtl/skip_seq_counter.sv
// Up/down counter that never shows codes whose low SKIP_W bits are all ones.
// Supports load with illegal-code correction and a registered wrap pulse.
module skip_seq_counter #(
  parameter int WIDTH  = 3,
  parameter int SKIP_W = 2
) (
  input logic              clk,
  input logic              clear,
  skip_seq_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] MASK =
    (SKIP_W == 0) ? '0 : (ONES >> (WIDTH - SKIP_W));
  localparam logic [WIDTH-1:0] MAX =
    (SKIP_W == 0) ? ONES : (ONES - WIDTH'(1));

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] inc, dec, ld;

  function automatic logic illegal(input logic [WIDTH-1:0] v);
    return (SKIP_W != 0) && ((v & MASK) == MASK);
  endfunction

  // Next count: load beats count; a step landing on a skipped code
  // moves one further, and wrapping at the ends raises tc.
  always_comb begin
    inc  = q_q + WIDTH'(1);
    dec  = q_q - WIDTH'(1);
    ld   = bus.din;
    if (illegal(bus.din)) ld[0] = 1'b0;
    q_d  = q_q;
    tc_d = 1'b0;
    if (bus.load) begin
      q_d = ld;
    end else if (bus.en) begin
      if (bus.up) begin
        if (q_q == MAX) begin
          q_d  = '0;
          tc_d = 1'b1;
        end else begin
          q_d = illegal(inc) ? inc + WIDTH'(1) : inc;
        end
      end else begin
        if (q_q == '0) begin
          q_d  = MAX;
          tc_d = 1'b1;
        end else begin
          q_d = illegal(dec) ? dec - WIDTH'(1) : dec;
        end
      end
    end
  end

  // State registers; clear wins over everything else.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign bus.q  = q_q;
  assign bus.tc = tc_q;

endmodule
